// File: rtl/uv_bus_arb_hold.sv
// N-master to 1-slave arbitration stage: fixed priority (lowest index wins),
// grant locked from request acceptance until the response handshake.
module uv_bus_arb_hold #(
  parameter int NUM_MST = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_MST-1:0]        mst_req_vld,
  output logic [NUM_MST-1:0]        mst_req_rdy,
  input  logic [NUM_MST-1:0]        mst_req_write,
  input  logic [NUM_MST*ADDR_W-1:0] mst_req_addr,
  input  logic [NUM_MST*DATA_W-1:0] mst_req_wdata,
  output logic [NUM_MST-1:0]        mst_rsp_vld,
  input  logic [NUM_MST-1:0]        mst_rsp_rdy,
  output logic [DATA_W-1:0]         mst_rsp_rdata,
  output logic                      slv_req_vld,
  input  logic                      slv_req_rdy,
  output logic                      slv_req_write,
  output logic [ADDR_W-1:0]         slv_req_addr,
  output logic [DATA_W-1:0]         slv_req_wdata,
  input  logic                      slv_rsp_vld,
  output logic                      slv_rsp_rdy,
  input  logic [DATA_W-1:0]         slv_rsp_rdata,
  output logic                      busy,
  output logic [NUM_MST-1:0]        sel_oh
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_MST-1:0]   sel_oh_q, sel_oh_d;
  logic                 sel_vld_s;

  // Isolate the lowest set bit: the fixed-priority winner.
  function automatic logic [NUM_MST-1:0] lowest_bit(input logic [NUM_MST-1:0] req);
    return req & ~(req - NUM_MST'(1));
  endfunction

  assign sel_vld_s = |(mst_req_vld & sel_oh_q);
  assign busy      = (state_q != ST_IDLE);
  assign sel_oh    = sel_oh_q;

  // State and owner registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sel_oh_q <= {NUM_MST{1'b0}};
    end else begin
      state_q  <= state_d;
      sel_oh_q <= sel_oh_d;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d       = state_q;
    sel_oh_d      = sel_oh_q;
    slv_req_vld   = 1'b0;
    mst_req_rdy   = {NUM_MST{1'b0}};
    mst_rsp_vld   = {NUM_MST{1'b0}};
    mst_rsp_rdata = {DATA_W{1'b0}};
    slv_rsp_rdy   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|mst_req_vld) begin
          sel_oh_d = lowest_bit(mst_req_vld);
          state_d  = ST_REQ;
        end else begin
          sel_oh_d = {NUM_MST{1'b0}};
        end
      end
      ST_REQ: begin
        slv_req_vld = sel_vld_s;
        mst_req_rdy = sel_oh_q & {NUM_MST{slv_req_rdy}};
        // A withdrawn request releases the grant without touching the slave.
        if (!sel_vld_s) begin
          state_d  = ST_IDLE;
          sel_oh_d = {NUM_MST{1'b0}};
        end else if (slv_req_rdy) begin
          state_d = ST_RSP;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_RSP: begin
        mst_rsp_vld   = sel_oh_q & {NUM_MST{slv_rsp_vld}};
        mst_rsp_rdata = slv_rsp_rdata;
        slv_rsp_rdy   = |(mst_rsp_rdy & sel_oh_q);
        if (slv_rsp_vld && slv_rsp_rdy) begin
          state_d  = ST_IDLE;
          sel_oh_d = {NUM_MST{1'b0}};
        end else begin
          state_d = ST_RSP;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        sel_oh_d = {NUM_MST{1'b0}};
      end
    endcase
  end

  // AND-OR payload mux; all zero whenever no master owns the bus.
  always_comb begin
    slv_req_write = 1'b0;
    slv_req_addr  = {ADDR_W{1'b0}};
    slv_req_wdata = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_MST; i++) begin
      slv_req_write = slv_req_write | (mst_req_write[i] & sel_oh_q[i]);
      slv_req_addr  = slv_req_addr  | (mst_req_addr[i*ADDR_W +: ADDR_W] & {ADDR_W{sel_oh_q[i]}});
      slv_req_wdata = slv_req_wdata | (mst_req_wdata[i*DATA_W +: DATA_W] & {DATA_W{sel_oh_q[i]}});
    end
  end

endmodule

// File: tb/tb_uv_bus_arb_hold.sv
// Directed bench for uv_bus_arb_hold with two masters and hand-computed expectations.
module tb_uv_bus_arb_hold;
  localparam int NUM_MST = 2;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_MST-1:0]        mst_req_vld;
  logic [NUM_MST-1:0]        mst_req_rdy;
  logic [NUM_MST-1:0]        mst_req_write;
  logic [NUM_MST*ADDR_W-1:0] mst_req_addr;
  logic [NUM_MST*DATA_W-1:0] mst_req_wdata;
  logic [NUM_MST-1:0]        mst_rsp_vld;
  logic [NUM_MST-1:0]        mst_rsp_rdy;
  logic [DATA_W-1:0]         mst_rsp_rdata;
  logic                      slv_req_vld;
  logic                      slv_req_rdy;
  logic                      slv_req_write;
  logic [ADDR_W-1:0]         slv_req_addr;
  logic [DATA_W-1:0]         slv_req_wdata;
  logic                      slv_rsp_vld;
  logic                      slv_rsp_rdy;
  logic [DATA_W-1:0]         slv_rsp_rdata;
  logic                      busy;
  logic [NUM_MST-1:0]        sel_oh;

  int pass_cnt  = 0;
  int total_cnt = 0;

  uv_bus_arb_hold #(.NUM_MST(NUM_MST), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .mst_req_vld(mst_req_vld), .mst_req_rdy(mst_req_rdy),
    .mst_req_write(mst_req_write), .mst_req_addr(mst_req_addr),
    .mst_req_wdata(mst_req_wdata),
    .mst_rsp_vld(mst_rsp_vld), .mst_rsp_rdy(mst_rsp_rdy),
    .mst_rsp_rdata(mst_rsp_rdata),
    .slv_req_vld(slv_req_vld), .slv_req_rdy(slv_req_rdy),
    .slv_req_write(slv_req_write), .slv_req_addr(slv_req_addr),
    .slv_req_wdata(slv_req_wdata),
    .slv_rsp_vld(slv_rsp_vld), .slv_rsp_rdy(slv_rsp_rdy),
    .slv_rsp_rdata(slv_rsp_rdata),
    .busy(busy), .sel_oh(sel_oh)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every output at its idle value.
  task automatic chk_idle(input string tag);
    chk({tag, ".busy"},        64'(busy),          64'd0);
    chk({tag, ".sel_oh"},      64'(sel_oh),        64'd0);
    chk({tag, ".slv_req_vld"}, 64'(slv_req_vld),   64'd0);
    chk({tag, ".mst_req_rdy"}, 64'(mst_req_rdy),   64'd0);
    chk({tag, ".mst_rsp_vld"}, 64'(mst_rsp_vld),   64'd0);
    chk({tag, ".slv_rsp_rdy"}, 64'(slv_rsp_rdy),   64'd0);
    chk({tag, ".addr"},        64'(slv_req_addr),  64'd0);
    chk({tag, ".wdata"},       64'(slv_req_wdata), 64'd0);
    chk({tag, ".write"},       64'(slv_req_write), 64'd0);
    chk({tag, ".rdata"},       64'(mst_rsp_rdata), 64'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    mst_req_vld   = 2'b11;
    mst_req_write = 2'b10;
    mst_req_addr  = {32'h0000_1000, 32'h0000_0100};
    mst_req_wdata = {32'hDEAD_BEEF, 32'h0000_AAAA};
    mst_rsp_rdy   = 2'b00;
    slv_req_rdy   = 1'b0;
    slv_rsp_vld   = 1'b0;
    slv_rsp_rdata = 32'h1234_5678;

    // Reset held with both masters requesting.
    #1;
    chk_idle("rst");
    tick();
    chk_idle("rst_clk");
    rst_n = 1'b1;
    tick();
    chk("rel.sel_oh",      64'(sel_oh),       64'h1);
    chk("rel.slv_req_vld", 64'(slv_req_vld),  64'd1);
    chk("rel.busy",        64'(busy),         64'd1);
    chk("rel.addr",        64'(slv_req_addr), 64'h100);
    chk("rel.write",       64'(slv_req_write),64'd0);
    chk("rel.mst_req_rdy", 64'(mst_req_rdy),  64'h0);

    // Master0 read handshake, then response back-pressured for 3 cycles.
    slv_req_rdy = 1'b1;
    #1;
    chk("m0.hs_rdy", 64'(mst_req_rdy), 64'h1);
    tick();
    slv_req_rdy = 1'b0;
    mst_req_vld = 2'b00;
    slv_rsp_vld = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rsp.mst_rsp_vld", 64'(mst_rsp_vld),   64'h1);
      chk("rsp.rdata",       64'(mst_rsp_rdata), 64'h1234_5678);
      chk("rsp.slv_rsp_rdy", 64'(slv_rsp_rdy),   64'd0);
      chk("rsp.slv_req_vld", 64'(slv_req_vld),   64'd0);
      chk("rsp.sel_oh",      64'(sel_oh),        64'h1);
      tick();
    end
    mst_rsp_rdy = 2'b01;
    #1;
    chk("rsp.done_rdy", 64'(slv_rsp_rdy), 64'd1);
    tick();
    // Response still offered in IDLE must not be accepted.
    mst_rsp_rdy = 2'b11;
    #1;
    chk_idle("idle_rsp");
    slv_rsp_vld = 1'b0;
    mst_rsp_rdy = 2'b00;

    // Master1 write; master0 joins one cycle later but cannot preempt.
    mst_req_vld = 2'b10;
    tick();
    chk("pri.sel_oh", 64'(sel_oh), 64'h2);
    mst_req_vld = 2'b11;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("wr.vld",   64'(slv_req_vld),   64'd1);
      chk("wr.write", 64'(slv_req_write), 64'd1);
      chk("wr.addr",  64'(slv_req_addr),  64'h0000_1000);
      chk("wr.wdata", 64'(slv_req_wdata), 64'hDEAD_BEEF);
      chk("wr.rdy",   64'(mst_req_rdy),   64'h0);
      chk("wr.sel",   64'(sel_oh),        64'h2);
      tick();
    end
    slv_req_rdy = 1'b1;
    #1;
    chk("wr.hs_rdy", 64'(mst_req_rdy), 64'h2);
    tick();
    slv_req_rdy = 1'b0;
    mst_req_vld = 2'b01;
    slv_rsp_vld = 1'b1;
    mst_rsp_rdy = 2'b10;
    #1;
    chk("wr.rsp_sel", 64'(sel_oh),      64'h2);
    chk("wr.rsp_vld", 64'(mst_rsp_vld), 64'h2);
    chk("wr.rsp_rdy", 64'(slv_rsp_rdy), 64'd1);
    chk("wr.req_rdy", 64'(mst_req_rdy), 64'h0);
    tick();
    slv_rsp_vld = 1'b0;
    mst_rsp_rdy = 2'b00;
    #1;
    chk("wr.idle_busy", 64'(busy),   64'd0);
    chk("wr.idle_sel",  64'(sel_oh), 64'h0);
    tick();
    chk("next.sel_oh", 64'(sel_oh),      64'h1);
    chk("next.vld",    64'(slv_req_vld), 64'd1);

    // Withdrawal while the slave stalls.
    mst_req_vld = 2'b00;
    #1;
    chk("wd.slv_req_vld", 64'(slv_req_vld), 64'd0);
    tick();
    chk("wd.sel_oh", 64'(sel_oh), 64'h0);
    chk("wd.busy",   64'(busy),   64'd0);

    // Reset asserted during RSP.
    mst_req_vld = 2'b01;
    slv_req_rdy = 1'b1;
    tick();
    tick();
    slv_req_rdy = 1'b0;
    slv_rsp_vld = 1'b1;
    #1;
    chk("mr.rsp_vld", 64'(mst_rsp_vld), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("mr");
    rst_n       = 1'b1;
    slv_rsp_vld = 1'b0;
    tick();
    chk("mr.regrant_sel", 64'(sel_oh),      64'h1);
    chk("mr.regrant_vld", 64'(slv_req_vld), 64'd1);
    chk("mr.regrant_addr",64'(slv_req_addr),64'h100);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/uv_bus_arb_hold.md
Name: uv_bus_arb_hold

Overview:
- N-master to 1-slave request/response arbitration stage built around fixed-priority arbitration: lowest index wins.
- Consumes per-master valid/ready requests, selects one master and locks the grant for that master's whole transaction, i.e. request accepted and response returned.
- Muxes the selected master's payload to the slave and routes the slave response back.
- Sits between several bus masters (core I/D ports, debug, DMA) and a shared slave port.

Parameters:
- NUM_MST, 2, number of masters (≥1).
- ADDR_W, 32, address width.
- DATA_W, 32, read/write data width.

Ports:
- clk  input  1  single clock; all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- mst_req_vld  input  NUM_MST  per-master request valid.
- mst_req_rdy  output  NUM_MST  per-master request accept.
- mst_req_write  input  NUM_MST  1 = write, 0 = read.
- mst_req_addr  input  NUM_MST*ADDR_W  flattened addresses; master i at [i*ADDR_W +: ADDR_W].
- mst_req_wdata  input  NUM_MST*DATA_W  flattened write data.
- mst_rsp_vld  output  NUM_MST  per-master response valid.
- mst_rsp_rdy  input  NUM_MST  per-master response accept.
- mst_rsp_rdata  output  DATA_W  response data, broadcast to all masters; qualified by mst_rsp_vld.
- slv_req_vld  output  1  request to slave.
- slv_req_rdy  input  1  slave accepts request.
- slv_req_write  output  1  muxed write flag.
- slv_req_addr  output  ADDR_W  muxed address.
- slv_req_wdata  output  DATA_W  muxed write data.
- slv_rsp_vld  input  1  slave response valid.
- slv_rsp_rdy  output  1  response accept to slave.
- slv_rsp_rdata  input  DATA_W  slave response data.
- busy  output  1  high in any state other than IDLE.
- sel_oh  output  NUM_MST  registered one-hot current owner; all zeros in IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, sel_oh=0.
  - All vld/rdy outputs 0; busy=0.
  - Payload outputs 0, because the mux is gated by sel_oh.
- Grant function: grant = req & ~(req-1), the lowest set bit of mst_req_vld. No starvation protection; fairness is not a goal of this block.
- State IDLE:
  - All outputs inactive.
  - If any mst_req_vld bit is set, register grant into sel_oh and go to REQ next cycle.
  - One-cycle arbitration latency; no combinational path from mst_req_vld to slv_req_vld.
- State REQ:
  - slv_req_vld = |(mst_req_vld & sel_oh).
  - slv_req_write/addr/wdata = AND-OR mux of the selected master's fields.
  - mst_req_rdy = sel_oh & {NUM_MST{slv_req_rdy}}; non-selected masters always see rdy=0.
  - slv_req_vld & slv_req_rdy → RSP.
  - If the selected master drops vld before the handshake (protocol violation, tolerated) → IDLE, sel_oh cleared, no slave request issued that cycle.
- State RSP:
  - mst_rsp_vld = sel_oh & {NUM_MST{slv_rsp_vld}}.
  - mst_rsp_rdata = slv_rsp_rdata.
  - slv_rsp_rdy = |(mst_rsp_rdy & sel_oh).
  - slv_rsp_vld & slv_rsp_rdy → IDLE, sel_oh cleared.
  - Request side held off: slv_req_vld=0, all mst_req_rdy=0.
- Single outstanding transaction. Minimum 3 cycles per transaction: IDLE→REQ→RSP→IDLE with zero-wait slave.
- Responses arriving in IDLE/REQ are not accepted: slv_rsp_rdy=0 and nothing is forwarded.
- Newly arriving higher-priority requests never preempt a locked grant; re-arbitration happens only in IDLE.
- Backpressure: payload and slv_req_vld stable while slv_req_rdy=0, provided the master holds its inputs. Response held while mst_rsp_rdy=0.
- Reset asserted mid-transaction aborts immediately to IDLE. The slave is expected to be reset in the same domain.
- NUM_MST=1: degenerates to a registered pass-through gate with the same state sequence.

Test Plan:
- Reset: rst_n=0 with mst_req_vld=2'b11 → all outputs 0, busy=0. Release → cycle+1 sel_oh=2'b01, slv_req_vld=1.
- Priority: mst_req_vld=2'b10, then 2'b11 asserted one cycle later → master1 keeps the grant (sel_oh=2'b10) through its response. Master0 is served next: IDLE→sel_oh=2'b01.
- Write transaction: master1 addr=0x0000_1000, wdata=0xDEAD_BEEF, write=1, slave rdy after 2 wait cycles → slv_req_* match exactly and stay stable over the waits. mst_req_rdy=2'b10 only in the handshake cycle.
- Read response: slv_rsp_rdata=0x1234_5678 with mst_rsp_rdy[0]=0 for 3 cycles → slv_rsp_rdy=0 and mst_rsp_vld=2'b01 held. Completes on rdy, then IDLE.
- Withdrawal: selected master drops vld in REQ with slv_req_rdy=0 → IDLE next cycle, sel_oh=0, no slave handshake.
- Mid-op reset: assert rst_n=0 during RSP → outputs 0 asynchronously. After release, a new request from master0 is granted normally.
